// File: rtl/mux_nbit_nto1_skid.sv
// N-way word multiplexer with a registered, skid-buffered valid/ready output stage.
// A stalled consumer never loses a beat, and streaming runs at one beat per cycle.

module mux_nbit_nto1_skid_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] gated
);
  logic hit;
  assign hit   = (sel == SEL_W'(IDX));
  assign gated = word & {WIDTH{hit}};
endmodule

module mux_nbit_nto1_skid #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [WIDTH*NUM_INPUTS-1:0] in_flat,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err,
  output logic [1:0]                  occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t                             state;
  logic [WIDTH-1:0]                   main_q, skid_q;
  logic                               skid_valid, ready_q, valid_q;
  logic [NUM_INPUTS-1:0][WIDTH-1:0]   gated;
  logic [WIDTH-1:0]                   word;
  logic                               accept, transfer;

  // One gate per input; out-of-range selects hit no lane and OR to zero.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    mux_nbit_nto1_skid_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(i)) u_lane (
      .word  (in_flat[i*WIDTH +: WIDTH]),
      .sel   (sel),
      .gated (gated[i])
    );
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_INPUTS; i++) word = word | gated[i];
  end

  assign accept    = in_valid & ready_q;
  assign transfer  = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out       = main_q;
  assign out_valid = valid_q;
  assign occupancy = state;

  // ready_q tracks ~skid_valid as its own flop so out_ready never reaches in_ready.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q  <= word;
          valid_q <= 1'b1;
          state   <= ONE;
        end
        ONE: begin
          if (accept && transfer) begin
            main_q <= word;
          end else if (accept) begin
            skid_q     <= word;
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
            state      <= FULL;
          end else if (transfer) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: if (transfer) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
          state      <= ONE;
        end
        default: begin
          state      <= EMPTY;
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  if ((1 << SEL_W) == NUM_INPUTS) begin : g_no_err
    assign sel_err = 1'b0;
  end else begin : g_err
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INPUTS - 1);
    logic err_q;
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)                        err_q <= 1'b0;
      else if (accept && sel > LAST)  err_q <= 1'b1;
    end
    assign sel_err = err_q;
  end

endmodule

// File: tb/tb_mux_nbit_nto1_skid.sv
// Directed and scoreboard checks for mux_nbit_nto1_skid (4-input and 3-input builds).

module tb_mux_nbit_nto1_skid;

  logic         Clk = 1'b0, Rst = 1'b0, clk_en = 1'b0;
  logic [127:0] in_flat;
  logic [1:0]   sel;
  logic         in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [31:0]  out;
  logic [1:0]   occupancy;

  logic [95:0]  in_flat3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [31:0]  out3;
  logic [1:0]   occupancy3;

  int n_chk = 0, n_pass = 0;

  mux_nbit_nto1_skid #(.WIDTH(32), .NUM_INPUTS(4)) u_dut (
    .Clk(Clk), .Rst(Rst), .in_flat(in_flat), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .occupancy(occupancy)
  );

  mux_nbit_nto1_skid #(.WIDTH(32), .NUM_INPUTS(3)) u_dut3 (
    .Clk(Clk), .Rst(Rst), .in_flat(in_flat3), .sel(sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out(out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3), .occupancy(occupancy3)
  );

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] w;
  logic        acc, tr;
  int          idx;

  initial begin
    in_flat   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_flat3  = {32'h33333333, 32'h22222222, 32'h11111111};
    sel = '0; in_valid = 0; out_ready = 0;
    sel3 = '0; in_valid3 = 0; out_ready3 = 0;

    // Asynchronous reset with the clock stopped
    #2 Rst = 1'b1;
    #1;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sel_err3", sel_err3, 0);
    #2 Rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    clk_en = 1'b1;

    // Full-throughput streaming
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_out", out, in_flat[i*32 +: 32]);
      chk("stream_out_valid", out_valid, 1);
    end
    in_valid = 0;
    tick();
    chk("drain_empty", occupancy, 0);
    chk("drain_valid", out_valid, 0);

    // Stall: fill the skid, third beat held off
    out_ready = 0; in_valid = 1; sel = 2;
    tick();
    chk("stall_out0", out, 32'h33333333);
    chk("stall_occ1", occupancy, 1);
    sel = 3;
    tick();
    chk("stall_occ2", occupancy, 2);
    chk("stall_in_ready0", in_ready, 0);
    sel = 1;
    tick();
    chk("stall_hold_out", out, 32'h33333333);
    chk("stall_hold_occ", occupancy, 2);
    out_ready = 1;
    tick();
    chk("unstall_out1", out, 32'h44444444);
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("unstall_out2", out, 32'h22222222);
    chk("unstall_occ", occupancy, 1);
    in_valid = 0;
    tick();
    chk("unstall_empty", out_valid, 0);

    // Out-of-range select on the 3-input build
    out_ready3 = 1; in_valid3 = 1; sel3 = 3;
    tick();
    chk("oob_out", out3, 0);
    chk("oob_valid", out_valid3, 1);
    chk("oob_err", sel_err3, 1);
    sel3 = 2;
    tick();
    chk("oob_next_out", out3, 32'h33333333);
    chk("oob_err_sticky", sel_err3, 1);
    chk("pow2_no_err", sel_err, 0);
    in_valid3 = 0;
    tick();

    // Reset while FULL
    out_ready = 0; in_valid = 1; sel = 0;
    tick();
    sel = 2;
    tick();
    in_valid = 0;
    chk("full_before_rst", occupancy, 2);
    #2 Rst = 1'b1;
    #1;
    chk("full_rst_occ", occupancy, 0);
    chk("full_rst_valid", out_valid, 0);
    chk("full_rst_in_ready", in_ready, 1);
    chk("full_rst_err3", sel_err3, 0);
    #1 Rst = 1'b0;
    in_valid = 1; sel = 1; out_ready = 1;
    tick();
    chk("after_rst_out", out, 32'h22222222);
    chk("after_rst_valid", out_valid, 1);
    chk("after_rst_occ", occupancy, 1);
    in_valid = 0;
    tick();
    chk("after_rst_drain", occupancy, 0);

    // Random traffic against a FIFO scoreboard
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_flat   = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = ($urandom_range(0, 3) != 0);
      chk("rnd_in_ready", in_ready, (q.size() < 2));
      idx = int'(sel);
      w   = in_flat[idx*32 +: 32];
      acc = in_valid && (q.size() < 2);
      tr  = (q.size() > 0) && out_ready;
      tick();
      if (tr)  void'(q.pop_front());
      if (acc) q.push_back(w);
      chk("rnd_occ", occupancy, q.size());
      chk("rnd_valid", out_valid, (q.size() > 0));
      if (q.size() > 0) chk("rnd_out", out, q[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
